// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single-issue ALU with a
// held result channel and a completed-operation counter.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_err,
    output logic             res_id,
    input  logic             res_ready,
    output logic             busy,
    output logic [CNTW-1:0]  done_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]       state_r;
    logic             last_grant_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       op_r;
    logic             id_r;
    logic             res_valid_r;
    logic [WIDTH-1:0] res_data_r;
    logic             res_zero_r;
    logic             res_err_r;
    logic             res_id_r;
    logic [CNTW-1:0]  done_cnt_r;

    logic             grant_s;
    logic             accept_s;
    logic [WIDTH-1:0] alu_data_s;
    logic             alu_err_s;

    // Result is {err, data}; unused op codes flag an error with a zero result.
    function automatic logic [WIDTH:0] alu_eval(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0] r;
        r = {1'b0, {WIDTH{1'b0}}};
        case (op)
            3'd0:    r = {1'b0, a & b};
            3'd1:    r = {1'b0, a | b};
            3'd2:    r = {1'b0, a + b};
            3'd3:    r = {1'b0, a - b};
            3'd7:    r = {1'b0, {(WIDTH-1){1'b0}}, (a < b)};
            default: r = {1'b1, {WIDTH{1'b0}}};
        endcase
        return r;
    endfunction

    // Round-robin grant; contention goes to the requester not granted last.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_r;
        end else begin
            grant_s = req1_valid;
        end
        accept_s   = (state_r == ST_IDLE) && (req0_valid || req1_valid);
        req0_ready = accept_s && !grant_s;
        req1_ready = accept_s && grant_s;
    end

    // ALU evaluation of the captured operands.
    always_comb begin
        {alu_err_s, alu_data_s} = alu_eval(op_r, a_r, b_r);
    end

    // Control FSM, operand capture, result register and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            op_r         <= 3'd0;
            id_r         <= 1'b0;
            res_valid_r  <= 1'b0;
            res_data_r   <= {WIDTH{1'b0}};
            res_zero_r   <= 1'b0;
            res_err_r    <= 1'b0;
            res_id_r     <= 1'b0;
            done_cnt_r   <= {CNTW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r          <= grant_s ? req1_a : req0_a;
                        b_r          <= grant_s ? req1_b : req0_b;
                        op_r         <= grant_s ? req1_op : req0_op;
                        id_r         <= grant_s;
                        last_grant_r <= grant_s;
                        state_r      <= ST_EXEC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    res_data_r  <= alu_data_s;
                    res_err_r   <= alu_err_s;
                    res_zero_r  <= (alu_data_s == {WIDTH{1'b0}});
                    res_id_r    <= id_r;
                    res_valid_r <= 1'b1;
                    state_r     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        done_cnt_r  <= done_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_r != ST_IDLE);
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_zero  = res_zero_r;
    assign res_err   = res_err_r;
    assign res_id    = res_id_r;
    assign done_cnt  = done_cnt_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_alu_arbiter;

    localparam int W = 32;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]   req0_op = 3'd0, req1_op = 3'd0;
    logic         req0_ready, req1_ready;
    logic         res_valid, res_zero, res_err, res_id;
    logic [W-1:0] res_data;
    logic         res_ready = 1'b0;
    logic         busy;
    logic [C-1:0] done_cnt;

    alu_arbiter #(.WIDTH(W), .CNTW(C)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_data(res_data), .res_zero(res_zero), .res_err(res_err), .res_id(res_id),
        .res_ready(res_ready), .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         id;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_data;
        logic         exp_err;
        logic         exp_zero;
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        logic         zero;
        logic         id;
    } res_t;

    vec_t vecs[11];
    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference ALU from the op-code table, using plain modular arithmetic.
    task automatic ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] data, output logic err);
        longint unsigned m, ua, ub;
        m = 64'h1_0000_0000;
        ua = a;
        ub = b;
        err = 1'b0;
        data = '0;
        case (op)
            3'd0: data = a & b;
            3'd1: data = a | b;
            3'd2: data = W'((ua + ub) % m);
            3'd3: data = W'((m + ua - ub) % m);
            3'd7: data = (ua < ub) ? W'(1) : W'(0);
            default: err = 1'b1;
        endcase
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", res_valid, 1'b0);
        check("rst_data", res_data, '0);
        check("rst_zero", res_zero, 1'b0);
        check("rst_err", res_err, 1'b0);
        check("rst_id", res_id, 1'b0);
        check("rst_done", done_cnt, '0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        exp_done = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        int n;
        if (v.id) begin
            req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
        end else begin
            req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
        end
        n = 0;
        @(negedge clk);
        while (!(v.id ? req1_ready : req0_ready) && n < 5) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("v%0d_accept", idx), v.id ? req1_ready : req0_ready, 1'b1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
        req0_op = 3'($urandom); req1_op = 3'($urandom);
        @(negedge clk);
        n = 1;
        while (!res_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("v%0d_latency", idx), n, 2);
        check($sformatf("v%0d_data", idx), res_data, v.exp_data);
        check($sformatf("v%0d_err", idx), res_err, v.exp_err);
        check($sformatf("v%0d_zero", idx), res_zero, v.exp_zero);
        check($sformatf("v%0d_id", idx), res_id, v.id);
        check($sformatf("v%0d_busy", idx), busy, 1'b1);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        exp_done = (exp_done + 1) % (1 << C);
        check($sformatf("v%0d_done", idx), done_cnt, exp_done);
        check($sformatf("v%0d_valid_clr", idx), res_valid, 1'b0);
        check($sformatf("v%0d_idle", idx), busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int grants[$];
        int ids[$];
        int n;
        bit both_rdy;

        vecs[0]  = '{1'b0, 3'd2, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
        vecs[1]  = '{1'b1, 3'd3, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[2]  = '{1'b0, 3'd2, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1'b1};
        vecs[3]  = '{1'b1, 3'd7, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1'b1};
        vecs[4]  = '{1'b0, 3'd5, 32'h1234,       32'h5678,       32'd0,          1'b1, 1'b1};
        vecs[5]  = '{1'b1, 3'd0, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  1'b0, 1'b0};
        vecs[6]  = '{1'b0, 3'd1, 32'hF000_0000,  32'h0000_000F,  32'hF000_000F,  1'b0, 1'b0};
        vecs[7]  = '{1'b1, 3'd7, 32'd1,          32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0};
        vecs[8]  = '{1'b0, 3'd4, 32'd9,          32'd3,          32'd0,          1'b1, 1'b1};
        vecs[9]  = '{1'b1, 3'd6, 32'hFFFF,       32'h1,          32'd0,          1'b1, 1'b1};
        vecs[10] = '{1'b0, 3'd0, 32'hAAAA_AAAA,  32'h5555_5555,  32'd0,          1'b0, 1'b1};

        do_reset();
        for (int i = 0; i < 11; i++) run_vector(vecs[i], i);

        // Contention straight after reset: grants must alternate starting with 0.
        do_reset();
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 32'd10; req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = 3'd2; req1_a = 32'd20; req1_b = 32'd2;
        res_ready = 1'b1;
        both_rdy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 16) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            if (req0_ready && req1_ready) both_rdy = 1'b1;
            if (req0_ready) grants.push_back(0);
            else if (req1_ready) grants.push_back(1);
            if (res_valid) begin
                ids.push_back(int'(res_id));
                exp_done = (exp_done + 1) % (1 << C);
            end
        end
        res_ready = 1'b0;
        check("cont_both_ready", both_rdy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cont_grant%0d", i), (i < grants.size()) ? grants[i] : 9, i % 2);
            check($sformatf("cont_id%0d", i), (i < ids.size()) ? ids[i] : 9, i % 2);
        end
        check("cont_done", done_cnt, exp_done);
        @(posedge clk);
        #1;

        // Backpressure: result must hold while both requesters keep asking.
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 32'h0F; req0_b = 32'h30;
        n = 0;
        @(negedge clk);
        while (!req0_ready && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("bp_accept", req0_ready, 1'b1);
        @(posedge clk);
        #1;
        req1_valid = 1'b1;
        req0_a = 32'hDEAD; req0_op = 3'd2;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            check("bp_valid", res_valid, 1'b1);
            check("bp_data", res_data, 32'h3F);
            check("bp_id", res_id, 1'b0);
            check("bp_err_zero", {res_err, res_zero}, 2'b00);
            check("bp_readies", {req0_ready, req1_ready}, 2'b00);
            check("bp_busy", busy, 1'b1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        exp_done = (exp_done + 1) % (1 << C);
        check("bp_done", done_cnt, exp_done);
        check("bp_valid_clr", res_valid, 1'b0);
        check("bp_idle", busy, 1'b0);

        // Reset while the operation is in EXEC.
        req1_valid = 1'b1; req1_op = 3'd2; req1_a = 32'd1; req1_b = 32'd1;
        n = 0;
        @(negedge clk);
        while (!req1_ready && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("mid_accept", req1_ready, 1'b1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_valid", res_valid, 1'b0);
        check("mid_done", done_cnt, '0);
        check("mid_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_done = 0;
        repeat (2) begin
            @(negedge clk);
            check("mid_no_result", res_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check("mid_grant", {req0_ready, req1_ready}, 2'b10);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_no_hs", busy, 1'b0);

        // Randomized run against a transaction-level model.
        do_reset();
        begin
            int   cyc, m_hs, m_done;
            bit   m_busy, m_last, exp_rv, g, e0, e1, hs, rhs;
            res_t r;
            cyc = 0; m_hs = 0; m_done = 0;
            m_busy = 1'b0; m_last = 1'b1;
            exp_q.delete();
            for (int k = 0; k < 700; k++) begin
                req0_valid = ($urandom_range(0, 9) < 6);
                req1_valid = ($urandom_range(0, 9) < 6);
                req0_op = 3'($urandom_range(0, 7));
                req1_op = 3'($urandom_range(0, 7));
                req0_a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                req0_b = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom;
                req1_a = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
                res_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                exp_rv = m_busy && (cyc >= m_hs + 1);
                g = 1'b0; e0 = 1'b0; e1 = 1'b0;
                if (!m_busy && (req0_valid || req1_valid)) begin
                    g  = (req0_valid && req1_valid) ? !m_last : req1_valid;
                    e0 = !g;
                    e1 = g;
                end
                check("rnd_ready", {req0_ready, req1_ready}, {e0, e1});
                check("rnd_busy", busy, m_busy);
                check("rnd_valid", res_valid, exp_rv);
                check("rnd_done", done_cnt, m_done);
                if (exp_rv && exp_q.size() > 0) begin
                    check("rnd_data", res_data, exp_q[0].data);
                    check("rnd_err", res_err, exp_q[0].err);
                    check("rnd_zero", res_zero, exp_q[0].zero);
                    check("rnd_id", res_id, exp_q[0].id);
                end
                hs  = e0 || e1;
                rhs = exp_rv && res_ready;
                if (hs) begin
                    if (g) ref_alu(req1_op, req1_a, req1_b, r.data, r.err);
                    else   ref_alu(req0_op, req0_a, req0_b, r.data, r.err);
                    r.zero = (r.data == 0);
                    r.id = g;
                    exp_q.push_back(r);
                end
                @(posedge clk);
                cyc++;
                if (hs) begin
                    m_busy = 1'b1;
                    m_hs = cyc;
                    m_last = g;
                end
                if (rhs) begin
                    m_busy = 1'b0;
                    void'(exp_q.pop_front());
                    m_done = (m_done + 1) % (1 << C);
                end
                #1;
            end
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
